// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// The decoder and the hazard unit import the same op codes.
package mdu_pkg;

  localparam int MDU_WIDTH       = 32;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  localparam logic [2:0] MDU_MULT  = 3'b000;
  localparam logic [2:0] MDU_MULTU = 3'b001;
  localparam logic [2:0] MDU_DIV   = 3'b010;
  localparam logic [2:0] MDU_DIVU  = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath producing {hi_next, lo_next}
// from latched operands, including divide-by-zero and overflow results.
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic               a_neg, b_neg;

  always_comb begin
    // Low 2W bits of the product of sign-extended operands is the signed product.
    a_sx  = {{WIDTH{a[WIDTH-1]}}, a};
    b_sx  = {{WIDTH{b[WIDTH-1]}}, b};
    a_zx  = {{WIDTH{1'b0}}, a};
    b_zx  = {{WIDTH{1'b0}}, b};
    a_neg = a[WIDTH-1];
    b_neg = b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    q_s   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_s   = a_neg ? -r_mag : r_mag;
    q_u   = a / b;
    r_u   = a % b;
    res   = '0;
    case (op)
      MDU_MULT:  res = a_sx * b_sx;
      MDU_MULTU: res = a_zx * b_zx;
      MDU_DIV: begin
        if (b == '0)                           res = {a, {WIDTH{1'b1}}};
        else if (a == MOST_NEG && b == '1)     res = {{WIDTH{1'b0}}, MOST_NEG};
        else                                   res = {r_s, q_s};
      end
      MDU_DIVU: begin
        if (b == '0) res = {a, {WIDTH{1'b1}}};
        else         res = {r_u, q_u};
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: FSM, latency counter, operand latches
// and the architectural HI/LO registers.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] calc_res;

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .res (calc_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_arith(op)) begin
            state_d = ST_RUN;
            op_d    = op;
            a_d     = data1;
            b_d     = data2;
            cnt_d   = (op == MDU_DIV || op == MDU_DIVU) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (op == MDU_MTHI) begin
            hi_d = data1;
          end else if (op == MDU_MTLO) begin
            lo_d = data1;
          end
        end
      end
      ST_RUN: begin
        // start is deliberately ignored here; the hazard unit stalls on busy.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          hi_d    = calc_res[2*WIDTH-1:WIDTH];
          lo_d    = calc_res[WIDTH-1:0];
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: cycle-level reference model plus literal result checks.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk, reset_n, start, busy, done;
  logic [2:0]  op;
  logic [31:0] data1, data2, hi, lo;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  mdu dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .data1(data1), .data2(data2), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference result from plain integer arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              ia, ib;
    logic [31:0]     q, r;
    sa = $signed(a); sb = $signed(b);
    ua = a; ub = b;
    ia = a; ib = b;
    case (o)
      MDU_MULT:  return sa * sb;
      MDU_MULTU: return ua * ub;
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = ia / ib; r = ia % ib;
        return {r, q};
      end
      MDU_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Model: remaining busy cycles, pending result, architectural HI/LO.
  int          m_rem;
  logic [63:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic        m_done;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem <= 0; m_pend <= '0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        if (m_rem == 1) begin
          m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; m_done <= 1'b1;
        end
        m_rem <= m_rem - 1;
      end else if (start) begin
        if (op == MDU_MULT || op == MDU_MULTU) begin
          m_rem <= 5; m_pend <= ref_res(op, data1, data2);
        end else if (op == MDU_DIV || op == MDU_DIVU) begin
          m_rem <= 10; m_pend <= ref_res(op, data1, data2);
        end else if (op == MDU_MTHI) m_hi <= data1;
        else if (op == MDU_MTLO) m_lo <= data1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_rem != 0});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  // Drive an issue for one cycle, then scramble operands to prove they were latched.
  task automatic issue_now(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; data1 = a; data2 = b;
    @(posedge clk); #2;
    start = 1'b0; op = MDU_MTHI; data1 = $urandom; data2 = $urandom;
  endtask

  task automatic wait_done(output int nb, output bit ok);
    nb = 0; ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
      if (busy) nb++;
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh, input logic [31:0] el);
    int nb; bit ok;
    issue_now(o, a, b);
    wait_done(nb, ok);
    chk({name, "_done_seen"}, {31'b0, ok}, 32'd1);
    chk({name, "_busy_cycles"}, nb, n);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
  endtask

  initial begin
    int nb; bit ok;
    reset_n = 0; start = 0; op = '0; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    #2 chk_en = 1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset_n = 1;
    @(negedge clk);

    run_op("mult",  MDU_MULT,  32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    @(negedge clk);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg", MDU_DIV,  32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",    MDU_DIVU, 32'h7, 32'h2, 10, 32'h1, 32'h3);
    run_op("div_by0", MDU_DIV,  32'h5, 32'h0, 10, 32'h5, 32'hFFFF_FFFF);
    run_op("divu_by0", MDU_DIVU, 32'h10, 32'h0, 10, 32'h10, 32'hFFFF_FFFF);
    run_op("div_ovf", MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    // Back-to-back: MULT issued in the done cycle of the preceding DIV.
    run_op("div_b2b", MDU_DIV,  32'd100, 32'hFFFF_FFF9, 10, 32'd2, 32'hFFFF_FFF2);
    run_op("mult_b2b", MDU_MULT, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    @(negedge clk);
    issue_now(MDU_MTHI, 32'h1234_5678, 32'h0);
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", {31'b0, busy}, 0);
    issue_now(MDU_MTLO, 32'hCAFE_0001, 32'h0);
    @(negedge clk);
    chk("mtlo_lo", lo, 32'hCAFE_0001);
    issue_now(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("nop_busy", {31'b0, busy}, 0);
    chk("nop_hi", hi, 32'h1234_5678);

    // MTLO during RUN is dropped.
    issue_now(MDU_MULT, 32'd3, 32'd4);
    @(negedge clk);
    issue_now(MDU_MTLO, 32'hDEAD_BEEF, 32'h0);
    @(negedge clk);
    chk("mtlo_run_hold", lo, 32'hCAFE_0001);
    wait_done(nb, ok);
    chk("mtlo_run_done_seen", {31'b0, ok}, 1);
    chk("mtlo_run_lo", lo, 32'd12);
    chk("mtlo_run_hi", hi, 32'd0);

    // Reset in the third busy cycle of a DIV.
    @(negedge clk);
    issue_now(MDU_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #1 reset_n = 0;
    #1;
    chk("rst_mid_busy", {31'b0, busy}, 0);
    chk("rst_mid_done", {31'b0, done}, 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    @(posedge clk); #2 reset_n = 1;
    repeat (15) @(negedge clk);
    chk("post_rst_hi", hi, 0);
    chk("post_rst_lo", lo, 0);
    chk("post_rst_busy", {31'b0, busy}, 0);

    run_op("after_rst", MDU_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised multi-cycle multiply/divide unit for the pipelined MIPS core; successor to the single-cycle combinational ALU. Executes signed/unsigned multiply and divide over a configurable latency, holds results in internal HI/LO registers, and supports direct HI/LO writes. Sits beside the ALU in the EX stage; the hazard unit stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU, ≥1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU, ≥1.
- `clk`  in  1  clock. Everything is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  issue `op` this cycle.
- `op`  in  3  operation code, from the shared package.
- `data1`  in  WIDTH  rs operand: dividend or multiplicand, or the MTHI/MTLO source.
- `data2`  in  WIDTH  rt operand: divisor or multiplier.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse on the cycle HI/LO become valid.
- `hi`  out  WIDTH  HI register. Always readable.
- `lo`  out  WIDTH  LO register. Always readable.

## Operation
- Op codes:
  - 000 MULT: {HI,LO} = signed product.
  - 001 MULTU: {HI,LO} = unsigned product.
  - 010 DIV: LO = signed quotient, truncated toward zero. HI = remainder, with the dividend's sign.
  - 011 DIVU: unsigned quotient and remainder.
  - 100 MTHI: HI = data1.
  - 101 MTLO: LO = data1.
  - 110 and 111: no-op.
- States are IDLE and RUN.
  - IDLE → RUN when `start` is high and op is MULT, MULTU, DIV or DIVU. Operands and op are latched and the counter is loaded with MULT_CYCLES or DIV_CYCLES.
  - RUN decrements the counter each cycle.
  - RUN → IDLE when the counter reaches 1. On that edge the result commits to HI/LO and `done` pulses.
- Results are computed from the latched operands. Operand inputs may change after the issue cycle without effect.
- Division by zero: HI = dividend, LO = all ones. Both signed and unsigned. Not an error.
- Signed overflow (most-negative ÷ −1): LO = most-negative, HI = 0.
- MTHI/MTLO in IDLE write on the same edge. They do not assert `busy` or `done`.
- `start` while in RUN is ignored for every op, including MTHI/MTLO. The pipeline must stall instead.
- Reset (asynchronous assert, any time, including mid-operation):
  - state goes to IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0;
  - any pending result is discarded.

## Timing
- Issue at edge E0 (with `start`=1 in the preceding cycle).
- `busy`=1 from E0 through E0+N−1, where N is the op's cycle count.
- HI/LO update and `done`=1 after edge E0+N. `busy`=0 in that same cycle.
- A new `start` is accepted in the cycle `done`=1, so back-to-back issue gives no dead cycle.
- MTHI/MTLO: value visible on `hi`/`lo` immediately after the issue edge.
- `hi`/`lo` hold their old values for the whole RUN period. They never show a partial result.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the op-code localparams `MDU_MULT` … `MDU_MTLO`;
  - default latency constants;
  - the `WIDTH` default.
  The decoder and the hazard unit use the same package.
- Sub-module `mdu_calc`: purely combinational. Takes latched operands and op; outputs 2×WIDTH-bit `{hi_next, lo_next}`, including the divide-by-zero and overflow rules.
- The top level holds the FSM, latency counter, operand latches and HI/LO registers.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002:
  - `busy` high exactly 5 cycles;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFE, `done` pulses once.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) ÷ 2:
  - after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 ÷ 2 → LO=3, HI=1.
- DIV 5 ÷ 0 → HI=5, LO=0xFFFFFFFF.
- DIV 0x80000000 ÷ 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x12345678 in IDLE:
  - HI=0x12345678 the next cycle, `busy` stays 0.
- MTLO issued during RUN:
  - ignored; LO holds its old value until the MULT commits.
- Back-to-back ops: a MULT issued in the `done` cycle of a DIV is accepted, and both results are correct.
- Reset mid-operation:
  - deassert `reset_n` at cycle 3 of a DIV → `busy`, `done`, `hi`, `lo` all 0 immediately;
  - after release, no stale commit ever occurs.
